// File: rtl/wb_data_arbiter_if.sv
// Signal bundle for the two-master Wishbone data arbiter: both master ports plus the shared slave port.
// The slave modport is the arbiter's view; the master modport is the view of whatever surrounds it.
interface wb_data_arbiter_if;
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic        m0_we_i;
    logic [31:0] m0_adr_i;
    logic [31:0] m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_stall_o;
    logic        m0_ack_o;
    logic        m0_err_o;
    logic [31:0] m0_dat_o;

    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic        m1_we_i;
    logic [31:0] m1_adr_i;
    logic [31:0] m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_stall_o;
    logic        m1_ack_o;
    logic        m1_err_o;
    logic [31:0] m1_dat_o;

    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_stall_i;
    logic        s_ack_i;
    logic        s_err_i;
    logic [31:0] s_dat_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        output m0_stall_o, m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        output m1_stall_o, m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_stall_i, s_ack_i, s_err_i, s_dat_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        input  m0_stall_o, m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        input  m1_stall_o, m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_stall_i, s_ack_i, s_err_i, s_dat_i
    );
endinterface

// File: rtl/wb_data_arbiter.sv
// Two-master pipelined Wishbone arbiter: round-robin on ties, grant held for the owner's whole
// cycle, and a one-cycle error to the owner when the slave leaves the bus idle for TIMEOUT cycles.
module wb_data_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    wb_data_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_gnt;
    logic [15:0] r_cnt;
    logic        r_to_err;
    logic        w_hold;
    logic        w_to_err;

    // NOTE: w_state_next gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) w_state_next = r_last_gnt ? GNT0 : GNT1;
                else if (bus.m0_cyc_i)            w_state_next = GNT0;
                else if (bus.m1_cyc_i)            w_state_next = GNT1;
            end
            GNT0:    if (!bus.m0_cyc_i) w_state_next = bus.m1_cyc_i ? GNT1 : IDLE;
            GNT1:    if (!bus.m1_cyc_i) w_state_next = bus.m0_cyc_i ? GNT0 : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Owner keeps the bus next cycle; only then may the idle counter advance or fire.
    assign w_hold   = (r_state != IDLE) && (w_state_next == r_state);
    assign w_to_err = r_to_err && !bus.s_ack_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (r_state == GNT0 && w_state_next != GNT0)      r_last_gnt <= 1'b0;
            else if (r_state == GNT1 && w_state_next != GNT1) r_last_gnt <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_to_err <= 1'b0;
            if (!w_hold || bus.s_ack_i || bus.s_err_i) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_LAST) begin
                r_cnt    <= '0;
                r_to_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        bus.m0_stall_o = 1'b1;
        bus.m0_ack_o   = 1'b0;
        bus.m0_err_o   = 1'b0;
        bus.m0_dat_o   = bus.s_dat_i;
        bus.m1_stall_o = 1'b1;
        bus.m1_ack_o   = 1'b0;
        bus.m1_err_o   = 1'b0;
        bus.m1_dat_o   = bus.s_dat_i;
        bus.s_cyc_o    = 1'b0;
        bus.s_stb_o    = 1'b0;
        bus.s_we_o     = 1'b0;
        bus.s_adr_o    = '0;
        bus.s_dat_o    = '0;
        bus.s_sel_o    = '0;
        case (r_state)
            GNT0: begin
                bus.s_cyc_o    = bus.m0_cyc_i;
                bus.s_stb_o    = bus.m0_stb_i;
                bus.s_we_o     = bus.m0_we_i;
                bus.s_adr_o    = bus.m0_adr_i;
                bus.s_dat_o    = bus.m0_dat_i;
                bus.s_sel_o    = bus.m0_sel_i;
                bus.m0_stall_o = bus.s_stall_i;
                bus.m0_ack_o   = bus.s_ack_i;
                bus.m0_err_o   = bus.s_err_i | w_to_err;
            end
            GNT1: begin
                bus.s_cyc_o    = bus.m1_cyc_i;
                bus.s_stb_o    = bus.m1_stb_i;
                bus.s_we_o     = bus.m1_we_i;
                bus.s_adr_o    = bus.m1_adr_i;
                bus.s_dat_o    = bus.m1_dat_i;
                bus.s_sel_o    = bus.m1_sel_i;
                bus.m1_stall_o = bus.s_stall_i;
                bus.m1_ack_o   = bus.s_ack_i;
                bus.m1_err_o   = bus.s_err_i | w_to_err;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/wb_data_arbiter.md
WB_DATA_ARBITER -- requirements
Module: wb_data_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: idle-bus cycles allowed before the arbiter forces an error; legal range 2..65535.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset.
REQ-004 m0_cyc_i / m1_cyc_i  input  1  cycle request, master 0 (core data port) / master 1 (DMA/debug).
REQ-005 m0_stb_i / m1_stb_i  input  1  strobe, pipelined Wishbone.
REQ-006 m0_we_i / m1_we_i  input  1  write enable.
REQ-007 m0_adr_i / m1_adr_i  input  32  byte address.
REQ-008 m0_dat_i / m1_dat_i  input  32  write data.
REQ-009 m0_sel_i / m1_sel_i  input  4  byte select.
REQ-010 m0_stall_o / m1_stall_o  output  1  stall to master.
REQ-011 m0_ack_o / m1_ack_o  output  1  acknowledge to master.
REQ-012 m0_err_o / m1_err_o  output  1  bus error to master.
REQ-013 m0_dat_o / m1_dat_o  output  32  read data to master.
REQ-014 s_cyc_o, s_stb_o, s_we_o  output  1  slave-side cycle, strobe, write enable.
REQ-015 s_adr_o, s_dat_o  output  32  slave-side address, write data; s_sel_o  output  4  byte select.
REQ-016 s_stall_i, s_ack_i, s_err_i  input  1  slave stall, ack, error; s_dat_i  input  32  slave read data.

Function
REQ-017 FSM states: IDLE, GNT0, GNT1; a registered last_gnt bit records the most recent grant.
REQ-018 IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> grant to the master not equal to last_gnt (round-robin); none -> stay.
REQ-019 Grant takes effect the cycle after the request is sampled; while in IDLE, both stall outputs = 1, s_cyc_o = s_stb_o = 0.
REQ-020 GNTx: remain while mx_cyc_i = 1; when mx_cyc_i = 0, go to GNTy if my_cyc_i = 1, else IDLE; last_gnt <= x on leaving.
REQ-021 GNTx: s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i; s_we/adr/dat/sel from master x; mx_stall_o = s_stall_i; mx_ack_o = s_ack_i; mx_err_o = s_err_i | to_err; mx_dat_o = s_dat_i.
REQ-022 Non-granted master: stall_o = 1, ack_o = 0, err_o = 0; dat_o = s_dat_i (don't-care).
REQ-023 Unused slave outputs when no grant: we = 0, adr = dat = 0, sel = 0.
REQ-024 Timeout counter (16-bit): cleared in IDLE, on any s_ack_i or s_err_i, and on grant change; otherwise increments each GNTx cycle with s_cyc_o = 1.
REQ-025 When counter == TIMEOUT-1, to_err register is set for exactly one cycle and the counter clears; to_err forces the granted master's err_o high that cycle.
REQ-026 Simultaneous s_ack_i and to_err: to_err suppressed (ack wins; counter clears).
REQ-027 Master dropping cyc mid-transfer: grant released per REQ-020; late s_ack_i/s_err_i after release is not routed to either master.
REQ-028 Output muxing is combinational from state; no added latency on ack/err/data paths.

Reset
REQ-029 reset_i = 0 asynchronously forces: state IDLE, last_gnt = 1 (master 0 wins first tie), counter = 0, to_err = 0.
REQ-030 During reset: all s_* outputs 0, both stall outputs 1, all ack/err outputs 0; reset mid-transfer aborts it with no ack/err.

Verification
REQ-031 m0_cyc/stb, adr=0x100, read; slave acks next cycle with 0xDEADBEEF -> s_cyc_o rises 1 cycle after request; m0_ack_o=1, m0_dat_o=0xDEADBEEF; m1_stall_o=1 throughout.
REQ-032 Both cyc_i rise same cycle after reset -> GNT0 first; m0 drops cyc -> GNT1 next cycle; repeat tie -> GNT0 (alternation).
REQ-033 TIMEOUT=4, m1 granted, slave never acks -> m1_err_o=1 for exactly one cycle 4 cycles after s_cyc_o rises; counter restarts.
REQ-034 Slave ack in the same cycle the counter would expire -> ack delivered, no err.
REQ-035 Assert reset_i=0 mid-GNT0 with stb high -> outputs immediately at reset values; after release, IDLE, no spurious ack.
REQ-036 m0 write sel=0x3, dat=0x1234 -> s_we_o=1, s_sel_o=0x3, s_dat_o=0x1234 while granted.
